mem_arbiter: RTL and testbench

- Shares the single external 8-bit async SRAM (cartridge ROM image plus work RAM) between two requesters.
  - Z80 side: address already translated to 22 bits by mem_mapper.
  - Loader side: SD/flash image loader that fills the ROM image before and during boot.
- Sequences SRAM strobes, stalls the Z80 through WAIT_n, and gives the loader req/ack access.
- Sits between mem_mapper/cpu bus logic and the top-level SRAM pins.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/sram_cycle.sv | 63 ++++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, grant and timing definitions for the SRAM arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RECOVER = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_LDR = 1'b1
   } grant_t;

   localparam int DEF_ACCESS_CYCLES = 2;
   localparam int DEF_ADDR_W        = 22;

endpackage

// File: rtl/sram_cycle.sv
// rtl/sram_cycle.sv - times one SRAM access and drives registered, glitch-free strobes
module sram_cycle
   import mem_arb_pkg::*;
#(
   parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
)(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic we,
   output logic ce_n,
   output logic oe_n,
   output logic we_n,
   output logic dq_oe,
   output logic capture,
   output logic done
);

   localparam logic [3:0] LAST   = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0] WE_END = 4'(ACCESS_CYCLES - 2);

   logic       active;
   logic       cur_we;
   logic [3:0] cnt;

   // we_n rises one cycle early so write data is held past the strobe edge
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         cur_we <= 1'b0;
         cnt    <= 4'd0;
         ce_n   <= 1'b1;
         oe_n   <= 1'b1;
         we_n   <= 1'b1;
         dq_oe  <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         cur_we <= we;
         cnt    <= 4'd0;
         ce_n   <= 1'b0;
         oe_n   <= we;
         we_n   <= ~we;
         dq_oe  <= we;
      end else if (active) begin
         if (cnt == LAST) begin
            active <= 1'b0;
            cnt    <= 4'd0;
            ce_n   <= 1'b1;
            oe_n   <= 1'b1;
            we_n   <= 1'b1;
            dq_oe  <= 1'b0;
         end else begin
            cnt <= cnt + 4'd1;
            if (cnt == WE_END)
               we_n <= 1'b1;
         end
      end
   end

   assign done    = active && (cnt == LAST);
   assign capture = done && !cur_we;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin sharing of one async SRAM between the Z80 and the image loader
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_di,
   output logic [7:0]        cpu_do,
   output logic              cpu_wait_n,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [7:0]        ldr_di,
   output logic [7:0]        ldr_do,
   output logic              ldr_ack,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_dq_o,
   input  logic [7:0]        sram_dq_i,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   arb_state_t        state, state_nxt;
   grant_t            last_grant, gnt_sel;
   logic              cpu_done, cpu_pend, start;
   logic              acc_capture, acc_done;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [7:0]        sel_di;

   // cpu_done masks a Z80 cycle that has already been served until it ends
   assign cpu_pend   = cpu_req & ~cpu_done;
   assign cpu_wait_n = ~cpu_pend;
   assign ldr_ack    = (state == ST_RECOVER) && (last_grant == GNT_LDR);

   assign sel_we   = (gnt_sel == GNT_CPU) ? cpu_we   : ldr_we;
   assign sel_addr = (gnt_sel == GNT_CPU) ? cpu_addr : ldr_addr;
   assign sel_di   = (gnt_sel == GNT_CPU) ? cpu_di   : ldr_di;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      gnt_sel   = GNT_CPU;
      unique case (state)
         ST_IDLE: begin
            if (cpu_pend && ldr_req) begin
               gnt_sel = (last_grant == GNT_CPU) ? GNT_LDR : GNT_CPU;
               start   = 1'b1;
            end else if (cpu_pend) begin
               gnt_sel = GNT_CPU;
               start   = 1'b1;
            end else if (ldr_req) begin
               gnt_sel = GNT_LDR;
               start   = 1'b1;
            end
            if (start)
               state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (acc_done)
               state_nxt = ST_RECOVER;
         end
         ST_RECOVER: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= GNT_LDR;
         cpu_done   <= 1'b0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         cpu_do     <= '0;
         ldr_do     <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            last_grant <= gnt_sel;
            sram_addr  <= sel_addr;
            sram_dq_o  <= sel_di;
         end
         if (acc_capture) begin
            if (last_grant == GNT_CPU)
               cpu_do <= sram_dq_i;
            else
               ldr_do <= sram_dq_i;
         end
         if (!cpu_req)
            cpu_done <= 1'b0;
         else if (acc_done && last_grant == GNT_CPU)
            cpu_done <= 1'b1;
      end
   end

   sram_cycle #(
      .ACCESS_CYCLES (ACCESS_CYCLES)
   ) u_cycle (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .we      (sel_we),
      .ce_n    (sram_ce_n),
      .oe_n    (sram_oe_n),
      .we_n    (sram_we_n),
      .dq_oe   (sram_dq_oe),
      .capture (acc_capture),
      .done    (acc_done)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against an SRAM and memory model
module tb_mem_arbiter;

   localparam int AW    = 22;
   localparam int AC    = 2;
   localparam int BOUND = 2 * (AC + 2);
   localparam logic [AW-1:0] CBASE = 22'h200000;
   localparam logic [AW-1:0] LBASE = 22'h100000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_di = '0;
   logic [7:0]    cpu_do;
   logic          cpu_wait_n;
   logic          ldr_req = 1'b0, ldr_we = 1'b0;
   logic [AW-1:0] ldr_addr = '0;
   logic [7:0]    ldr_di = '0;
   logic [7:0]    ldr_do;
   logic          ldr_ack;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_dq_o, sram_dq_i;
   logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
      .cpu_do(cpu_do), .cpu_wait_n(cpu_wait_n),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_di(ldr_di),
      .ldr_do(ldr_do), .ldr_ack(ldr_ack),
      .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
      .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   // SRAM model with a back-door poke port for preloading
   logic [7:0]    sram_mem [0:(1<<AW)-1];
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_a = '0;
   logic [7:0]    poke_d = '0;
   int            cyc = 0;
   int            acc_starts = 0;
   logic          ce_q = 1'b1;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      ce_q <= sram_ce_n;
      if (ce_q && !sram_ce_n)
         acc_starts <= acc_starts + 1;
      if (poke_en)
         sram_mem[poke_a] <= poke_d;
      else if (!sram_ce_n && !sram_we_n && sram_dq_oe)
         sram_mem[sram_addr] <= sram_dq_o;
   end

   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'hFF;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
      poke_a = a; poke_d = d; poke_en = 1'b1;
      tick();
      poke_en = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (sram_ce_n && n < BOUND) begin tick(); n++; end
      chk(tag, 32'(sram_ce_n), 32'd0);
   endtask

   // reference-model state for the random phase
   logic [7:0] cmem [16], lmem [16];
   bit         cval [16], lval [16];
   bit         cpu_busy, ldr_busy, cpu_rd_chk, ldr_rd_chk, tie_cpu, last_cpu, held;
   logic [7:0] cpu_rd_exp, ldr_rd_exp;
   int         cpu_t0, ldr_t0, idx, n, base_starts, prev_ack;

   task automatic ldr_issue();
      idx = int'($urandom_range(0, 15));
      ldr_addr = LBASE + AW'(idx);
      ldr_we   = 1'($urandom_range(0, 1));
      ldr_di   = 8'($urandom);
      if (ldr_we) begin lmem[idx] = ldr_di; lval[idx] = 1'b1; end
      else begin ldr_rd_chk = lval[idx]; ldr_rd_exp = lmem[idx]; end
      ldr_req = 1'b1; ldr_busy = 1'b1; ldr_t0 = cyc;
   endtask

   task automatic cpu_issue();
      idx = int'($urandom_range(0, 15));
      cpu_addr = CBASE + AW'(idx);
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_di   = 8'($urandom);
      if (cpu_we) begin cmem[idx] = cpu_di; cval[idx] = 1'b1; end
      else begin cpu_rd_chk = cval[idx]; cpu_rd_exp = cmem[idx]; end
      cpu_req = 1'b1; cpu_busy = 1'b1; cpu_t0 = cyc;
   endtask

   initial begin
      // reset values
      do_reset();
      chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
      chk("rst_cpu_do", 32'(cpu_do), 32'd0);
      chk("rst_ldr_do", 32'(ldr_do), 32'd0);
      chk("rst_ldr_ack", 32'(ldr_ack), 32'd0);
      chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);

      // CPU read, uncontended
      poke(22'h0ABCDE, 8'h5A);
      cpu_addr = 22'h0ABCDE; cpu_we = 1'b0; cpu_req = 1'b1; #1;
      chk("rd_t0_wait", 32'(cpu_wait_n), 32'd0);
      tick();
      chk("rd_t1_ce", 32'(sram_ce_n), 32'd0);
      chk("rd_t1_oe", 32'(sram_oe_n), 32'd0);
      chk("rd_t1_we", 32'(sram_we_n), 32'd1);
      chk("rd_t1_dqoe", 32'(sram_dq_oe), 32'd0);
      chk("rd_t1_addr", 32'(sram_addr), 32'h0ABCDE);
      chk("rd_t1_wait", 32'(cpu_wait_n), 32'd0);
      tick();
      chk("rd_t2_ce", 32'(sram_ce_n), 32'd0);
      chk("rd_t2_oe", 32'(sram_oe_n), 32'd0);
      chk("rd_t2_wait", 32'(cpu_wait_n), 32'd0);
      tick();
      chk("rd_t3_ce", 32'(sram_ce_n), 32'd1);
      chk("rd_t3_oe", 32'(sram_oe_n), 32'd1);
      chk("rd_t3_wait", 32'(cpu_wait_n), 32'd1);
      chk("rd_t3_data", 32'(cpu_do), 32'h5A);
      cpu_req = 1'b0;
      tick();

      // loader write
      ldr_addr = 22'h000100; ldr_di = 8'hC3; ldr_we = 1'b1; ldr_req = 1'b1; #1;
      chk("wr_t0_ack", 32'(ldr_ack), 32'd0);
      tick();
      chk("wr_t1_we", 32'(sram_we_n), 32'd0);
      chk("wr_t1_dqoe", 32'(sram_dq_oe), 32'd1);
      chk("wr_t1_ce", 32'(sram_ce_n), 32'd0);
      chk("wr_t1_oe", 32'(sram_oe_n), 32'd1);
      chk("wr_t1_dq", 32'(sram_dq_o), 32'hC3);
      chk("wr_t1_addr", 32'(sram_addr), 32'h100);
      tick();
      chk("wr_t2_we", 32'(sram_we_n), 32'd1);
      chk("wr_t2_dqoe", 32'(sram_dq_oe), 32'd1);
      chk("wr_t2_ack", 32'(ldr_ack), 32'd0);
      tick();
      chk("wr_t3_ack", 32'(ldr_ack), 32'd1);
      chk("wr_t3_dqoe", 32'(sram_dq_oe), 32'd0);
      chk("wr_t3_ce", 32'(sram_ce_n), 32'd1);
      ldr_req = 1'b0;
      tick();
      chk("wr_t4_ack", 32'(ldr_ack), 32'd0);
      chk("wr_mem", 32'(sram_mem[22'h000100]), 32'hC3);
      chk("wr_ldr_do_kept", 32'(ldr_do), 32'd0);
      chk("wr_cpu_do_kept", 32'(cpu_do), 32'h5A);

      // one access per Z80 cycle even with cpu_req held
      base_starts = acc_starts;
      cpu_addr = 22'h0ABCDE; cpu_we = 1'b0; cpu_req = 1'b1; #1;
      n = 0;
      while (!cpu_wait_n && n < BOUND) begin tick(); n++; end
      chk("hold_latency", 32'(n), 32'(AC + 1));
      held = 1'b1;
      for (int i = 0; i < 10; i++) begin tick(); if (!cpu_wait_n) held = 1'b0; end
      chk("hold_wait_high", 32'(held), 32'd1);
      chk("hold_one_access", 32'(acc_starts - base_starts), 32'd1);
      cpu_req = 1'b0; tick();
      cpu_req = 1'b1; #1;
      chk("rereq_wait", 32'(cpu_wait_n), 32'd0);
      n = 0;
      while (!cpu_wait_n && n < BOUND) begin tick(); n++; end
      chk("rereq_done", 32'(cpu_wait_n), 32'd1);
      chk("rereq_two_access", 32'(acc_starts - base_starts), 32'd2);
      cpu_req = 1'b0; tick();

      // round-robin over 8 ties; CPU wins the first after reset
      do_reset();
      cpu_addr = 22'h0ABCDE; cpu_we = 1'b0;
      ldr_addr = 22'h000300; ldr_we = 1'b1; ldr_di = 8'h20;
      cpu_req = 1'b1; ldr_req = 1'b1;
      last_cpu = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wait_start("tie_start");
         tie_cpu = !last_cpu;
         chk("tie_winner", 32'(sram_addr), tie_cpu ? 32'(cpu_addr) : 32'(ldr_addr));
         tick(); tick();
         if (tie_cpu) begin
            chk("tie_cpu_done", 32'(cpu_wait_n), 32'd1);
            chk("tie_cpu_noack", 32'(ldr_ack), 32'd0);
            cpu_req = 1'b0; tick();
            cpu_req = 1'b1;
         end else begin
            chk("tie_ldr_ack", 32'(ldr_ack), 32'd1);
            ldr_addr = ldr_addr + 22'd1; ldr_di = ldr_di + 8'd1;
            tick();
         end
         last_cpu = tie_cpu;
      end
      cpu_req = 1'b0; ldr_req = 1'b0;
      tick(); tick();

      // back-to-back loader writes at the top of the address space
      poke(22'h000000, 8'hA5);
      ldr_we = 1'b1; ldr_addr = 22'h3FFFFC; ldr_di = 8'h90; ldr_req = 1'b1;
      prev_ack = 0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!ldr_ack && n < BOUND) begin tick(); n++; end
         chk("b2b_ack", 32'(ldr_ack), 32'd1);
         if (i > 0) chk("b2b_spacing", 32'(cyc - prev_ack), 32'(AC + 2));
         prev_ack = cyc;
         if (i < 3) begin ldr_addr = ldr_addr + 22'd1; ldr_di = ldr_di + 8'd1; end
         else ldr_req = 1'b0;
         tick();
      end
      tick();
      for (int i = 0; i < 4; i++)
         chk("b2b_mem", 32'(sram_mem[22'h3FFFFC + 22'(i)]), 32'(8'h90 + 8'(i)));
      chk("b2b_nowrap", 32'(sram_mem[22'h000000]), 32'hA5);

      // reset during the first ACCESS cycle of a loader write
      ldr_addr = 22'h000200; ldr_di = 8'h77; ldr_we = 1'b1; ldr_req = 1'b1;
      tick();
      chk("rstmid_active", 32'(sram_ce_n), 32'd0);
      rst = 1'b1;
      tick();
      chk("rstmid_ce", 32'(sram_ce_n), 32'd1);
      chk("rstmid_we", 32'(sram_we_n), 32'd1);
      chk("rstmid_oe", 32'(sram_oe_n), 32'd1);
      chk("rstmid_dqoe", 32'(sram_dq_oe), 32'd0);
      chk("rstmid_ack", 32'(ldr_ack), 32'd0);
      chk("rstmid_cpu_do", 32'(cpu_do), 32'd0);
      rst = 1'b0; ldr_req = 1'b0;
      held = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); if (ldr_ack) held = 1'b1; end
      chk("rstmid_no_ack", 32'(held), 32'd0);
      cpu_addr = 22'h0ABCDE; cpu_we = 1'b0; cpu_req = 1'b1; #1;
      chk("rstmid_cpu_wait", 32'(cpu_wait_n), 32'd0);
      n = 0;
      while (!cpu_wait_n && n < BOUND) begin tick(); n++; end
      chk("rstmid_cpu_lat", 32'(n), 32'(AC + 1));
      chk("rstmid_cpu_data", 32'(cpu_do), 32'h5A);
      cpu_req = 1'b0; tick();

      // randomized concurrent traffic against a memory model, disjoint regions per requester
      do_reset();
      cpu_busy = 1'b0; ldr_busy = 1'b0;
      for (int i = 0; i < 16; i++) begin cval[i] = 1'b0; lval[i] = 1'b0; end
      for (int c = 0; c < 1500; c++) begin
         chk("bus_contention", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
         if (cpu_busy && cpu_wait_n) begin
            chk("cpu_latency", 32'((cyc - cpu_t0) <= BOUND), 32'd1);
            if (cpu_rd_chk && !cpu_we) chk("cpu_rd_data", 32'(cpu_do), 32'(cpu_rd_exp));
            cpu_req = 1'b0; cpu_busy = 1'b0;
         end else if (!cpu_busy && c < 1400 && $urandom_range(0, 3) == 0) begin
            cpu_issue();
         end
         if (ldr_busy && ldr_ack) begin
            chk("ldr_latency", 32'((cyc - ldr_t0) <= BOUND), 32'd1);
            if (ldr_rd_chk && !ldr_we) chk("ldr_rd_data", 32'(ldr_do), 32'(ldr_rd_exp));
            ldr_busy = 1'b0; ldr_req = 1'b0;
            if (c < 1400 && $urandom_range(0, 1) == 1) ldr_issue();
         end else if (!ldr_busy && c < 1400 && $urandom_range(0, 3) == 0) begin
            ldr_issue();
         end
         tick();
      end
      chk("rand_cpu_drained", 32'(cpu_busy), 32'd0);
      chk("rand_ldr_drained", 32'(ldr_busy), 32'd0);
      for (int i = 0; i < 16; i++) begin
         if (cval[i]) chk("rand_cpu_mem", 32'(sram_mem[CBASE + 22'(i)]), 32'(cmem[i]));
         if (lval[i]) chk("rand_ldr_mem", 32'(sram_mem[LBASE + 22'(i)]), 32'(lmem[i]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
